mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-port synchronous RAM between the instruction-fetch port and the load/store (lw/sw) port of the RISC-V core. Grants one access at a time, counts the read latency, and returns read data with a one-cycle ready pulse. Drives a `stall` signal that holds the PC and register-file write enable until every pending access completes. Sits between the core datapath (PC/IF logic, ALU address output, `MemWriteEn`) and the unified instruction/data memory.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width from the core.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: cycles from issue (`mem_en`=1 edge) to valid `mem_rdata`. Legal range is 1..4.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch byte address (PC).
- `if_rdata`  out  DATA_W  fetched instruction; held until the next fetch completes.
- `if_ready`  out  1  one-cycle pulse: fetch done, `if_rdata` valid.
- `d_req`  in  1  data request; held until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; held until the next load completes.
- `d_ready`  out  1  one-cycle pulse: data access done.
- `mem_en`  out  1  RAM access strobe; high for exactly one cycle per access.
- `mem_we`  out  1  RAM write enable; valid only with `mem_en`.
- `mem_addr`  out  ADDR_W-2  word address = `addr[ADDR_W-1:2]`.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data; valid MEM_LAT cycles after issue.
- `stall`  out  1  `(if_req & ~if_ready) | (d_req & ~d_ready)`; combinational.

## Operation
- FSM states:
  - IDLE
  - BUSY_IF
  - BUSY_D
  - DONE
- A 3-bit latency counter `cnt` is loaded with MEM_LAT-1 at issue.
- IDLE, issue behaviour:
  - If `d_req` is high, issue data. Outputs are Mealy/combinational in this cycle: `mem_en`=1, `mem_we`=`d_we`, `mem_addr`/`mem_wdata` from the d-port. Next state is BUSY_D.
  - Else if `if_req` is high, issue fetch: `mem_en`=1, `mem_we`=0, `mem_addr` from `if_addr`. Next state is BUSY_IF.
  - Else stay in IDLE with `mem_en`=0.
- Fixed priority: data wins over fetch. A simultaneous fetch waits; it is issued from IDLE after the data access completes, if `if_req` is still high.
- BUSY_IF / BUSY_D: decrement `cnt` each cycle. The completion cycle is the cycle in which `cnt`==0.
  - Read completion: capture `mem_rdata` into the granted port's rdata register and pulse the port's ready in the same cycle. `rdata` is visible from the following cycle. The ready pulse is combinational from state and `cnt`, and the core samples `mem_rdata` forwarded through the rdata mux in that cycle.
  - Store completion: `d_ready` pulses in the cycle after issue regardless of MEM_LAT, i.e. `cnt` is forced to 0 at issue. `d_rdata` is unchanged.
- After the completion cycle, go to DONE for one cycle, then IDLE. DONE absorbs the requester's deassert or update of `req`/`addr` so that a stale request is not reissued.
- Throughput: one access per MEM_LAT+2 cycles for reads and 3 cycles for stores.
- A requester that drops `req` mid-access does not abort it. The access completes and the ready still pulses.
- Port inputs are sampled only at issue. Changes to address or data while BUSY are ignored.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0
  - `if_rdata` = `d_rdata` = 0
  - `if_ready` = `d_ready` = 0
  - `mem_en` = `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `stall` follows its equation.
- `rst` asserted mid-access returns to IDLE on that edge. The in-flight access produces no ready pulse, and any late `mem_rdata` is discarded. A store already issued is not recalled, because the RAM has already committed it.
- Read latency, issue cycle to ready pulse: MEM_LAT cycles.
  - MEM_LAT=1: issue in cycle t, ready in t+1, next issue no earlier than t+3.
- `mem_en` is never high in BUSY_*, DONE, or reset cycles.
- `if_ready` and `d_ready` are never high in the same cycle.

## Test plan
- Reset, then idle: with `rst`=1 for 2 cycles, all outputs are 0 and `stall`=0. With `if_req`=0 and `d_req`=0 thereafter, `mem_en` stays 0.
- Single fetch, MEM_LAT=2:
  - Stimulus: `if_addr`=0x0000_0010, RAM word 4 = 0x0010_0093.
  - `mem_en`=1 with `mem_addr`=4 in cycle t; `if_ready` pulses at t+2 with data 0x0010_0093; `stall`=1 during t..t+1.
- Collision:
  - Stimulus: `if_req` and `d_req` (load, `d_addr`=0x20) asserted in the same cycle.
  - Data is issued first with `mem_addr`=8; `d_ready` pulses at t+2; fetch is issued at t+4; `if_ready` pulses at t+6.
- Store:
  - Stimulus: `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEAD_BEEF.
  - `mem_we`=1 for one cycle with `mem_addr`=0x10; `d_ready` pulses at t+1; a subsequent load of 0x40 returns 0xDEAD_BEEF.
- Reset mid-read: a fetch is issued at t and `rst`=1 at t+1. No `if_ready` pulse occurs, the FSM is in IDLE at t+2, and `if_rdata`=0.
- Request dropped mid-access: `if_req` is deasserted at t+1. `if_ready` still pulses at t+2, and no reissue follows.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Data has fixed priority; each access runs issue -> latency countdown -> done -> idle.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    store_d   = store_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr[ADDR_W-1:2];
          mem_wdata = d_wdata;
          store_d   = d_we;
          // stores complete on the very next cycle, independent of read latency
          cnt_d     = d_we ? 3'd0 : LAT_M1;
          state_d   = BUSY_D;
        end else if (if_req) begin
          mem_en    = 1'b1;
          mem_addr  = if_addr[ADDR_W-1:2];
          store_d   = 1'b0;
          cnt_d     = LAT_M1;
          state_d   = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (cnt_q == 3'd0) begin
          if_ready = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      BUSY_D: begin
        if (cnt_q == 3'd0) begin
          d_ready = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A reset cycle neither issues nor completes anything.
    if (rst) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_ready  = 1'b0;
      d_ready   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      if (if_ready) if_rdata_q <= mem_rdata;
      if (d_ready && !store_q) d_rdata_q <= mem_rdata;
    end
  end

  // RAM data is forwarded during the ready cycle so the core can use it immediately.
  assign if_rdata = if_ready ? mem_rdata : if_rdata_q;
  assign d_rdata  = (d_ready && !store_q) ? mem_rdata : d_rdata_q;
  assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule
